// File: rtl/icache_fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: reset PC default, instruction buffer entry layout
// and FSM state encodings.
package icache_fetch_ctrl_pkg;

  localparam logic [29:0] RESET_PC_DEF = 30'h0;

  localparam logic [0:0] STATE_RUN  = 1'b0;
  localparam logic [0:0] STATE_HALT = 1'b1;

  // Buffer entry layout {error[62], addr[61:32], insn[31:0]}
  typedef struct packed {
    logic        error;
    logic [29:0] addr;
    logic [31:0] insn;
  } fetch_entry_t;

  function automatic logic [29:0] next_pc(input logic [29:0] pc);
    return pc + 30'd1;
  endfunction

endpackage

// File: rtl/icache_fetch_ctrl_fifo.sv
// Synchronous instruction buffer; clear has priority over push and pop, push+pop on full is legal.
module icache_fetch_ctrl_fifo #(
  parameter int WIDTH = 63,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic [WIDTH-1:0]             head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & ~clear & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/icache_fetch_ctrl.sv
// Fetch sequencer: issues sequential icache reads under a credit limit that reserves a buffer
// slot for every in-flight read, and buffers responses toward decode.
module icache_fetch_ctrl
  import icache_fetch_ctrl_pkg::*;
#(
  parameter logic [29:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 4,
  parameter int          IC_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_pc,
  output logic        fetch_ic_req,
  output logic [29:0] fetch_ic_addr,
  output logic        fetch_ic_flush,
  input  logic        icache_ready,
  input  logic        icache_valid,
  input  logic        icache_error,
  input  logic [31:0] icache_data,
  output logic        fetch_de_valid,
  output logic [29:0] fetch_de_addr,
  output logic [31:0] fetch_de_insn,
  output logic        fetch_de_error,
  input  logic        de_fetch_ready
);

  localparam int          IW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [IW:0] CREDIT_MAX = FIFO_DEPTH[IW:0];

  if (IC_LATENCY > FIFO_DEPTH) begin : g_latency_check
    $error("IC_LATENCY larger than FIFO_DEPTH cannot sustain the in-flight window");
  end

  logic [29:0]   pc;
  logic [29:0]   resp_pc;
  logic [IW-1:0] inflight;
  logic [0:0]    state;
  logic [IW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full_unused;
  logic          credit_ok;
  logic          issue;
  logic          resp;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic [$bits(fetch_entry_t)-1:0] fifo_head;

  // A pop only returns credit through fifo_count next cycle; no same-cycle bypass.
  assign credit_ok      = ({1'b0, inflight} + {1'b0, fifo_count}) < CREDIT_MAX;
  assign fetch_ic_req   = rst & (state == STATE_RUN) & ~redirect_valid & credit_ok;
  assign fetch_ic_addr  = pc;
  assign fetch_ic_flush = ~rst | redirect_valid;

  assign issue = fetch_ic_req & icache_ready;
  assign resp  = rst & icache_valid & ~redirect_valid;
  assign push  = resp & (state == STATE_RUN);
  assign pop   = de_fetch_ready & ~fifo_empty;

  assign push_entry = '{error: icache_error, addr: resp_pc, insn: icache_data};

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      state    <= STATE_RUN;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      resp_pc  <= redirect_pc;
      inflight <= '0;
      state    <= STATE_RUN;
    end else begin
      if (issue) pc <= next_pc(pc);
      if (push)  resp_pc <= next_pc(resp_pc);
      case ({issue, resp})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
      // Younger responses after a fault are dropped while halted.
      if (push && icache_error) state <= STATE_HALT;
    end
  end

  icache_fetch_ctrl_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full_unused),
    .head  (fifo_head)
  );

  assign head_entry     = fetch_entry_t'(fifo_head);
  assign fetch_de_valid = ~fifo_empty;
  assign fetch_de_addr  = head_entry.addr;
  assign fetch_de_insn  = head_entry.insn;
  assign fetch_de_error = head_entry.error;

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Bench for icache_fetch_ctrl: fixed-latency icache model, per-cycle vector table and an
// in-order scoreboard of expected decode entries.
module tb_icache_fetch_ctrl;

  localparam logic [29:0] RPC = 30'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [29:0] redirect_pc;
  logic        fetch_ic_req;
  logic [29:0] fetch_ic_addr;
  logic        fetch_ic_flush;
  logic        icache_ready;
  logic        icache_valid;
  logic        icache_error;
  logic [31:0] icache_data;
  logic        fetch_de_valid;
  logic [29:0] fetch_de_addr;
  logic [31:0] fetch_de_insn;
  logic        fetch_de_error;
  logic        de_fetch_ready;

  always #5 clk = ~clk;

  icache_fetch_ctrl #(.RESET_PC(RPC), .FIFO_DEPTH(4), .IC_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_ic_req(fetch_ic_req), .fetch_ic_addr(fetch_ic_addr), .fetch_ic_flush(fetch_ic_flush),
    .icache_ready(icache_ready), .icache_valid(icache_valid), .icache_error(icache_error),
    .icache_data(icache_data), .fetch_de_valid(fetch_de_valid), .fetch_de_addr(fetch_de_addr),
    .fetch_de_insn(fetch_de_insn), .fetch_de_error(fetch_de_error),
    .de_fetch_ready(de_fetch_ready)
  );

  typedef struct packed {
    logic        err;
    logic [29:0] addr;
    logic [31:0] insn;
  } exp_t;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [29:0] addr;
    logic        dv;
    logic [29:0] da;
  } vec_t;

  exp_t        sbq[$];
  vec_t        tab[15];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [29:0] exp_pc;
  logic        seen_err;
  logic        err_en;
  logic [29:0] err_addr;
  logic        acc_s, flush_s;
  logic [29:0] addr_s;
  logic        s1_v, s2_v;
  logic [29:0] s1_a, s2_a;

  function automatic logic [31:0] insn_of(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5a5a0f0f;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, want);
  endtask

  // Sample and score in the middle of the cycle.
  task automatic half_a();
    exp_t e;
    @(negedge clk);
    acc_s   = fetch_ic_req & icache_ready;
    addr_s  = fetch_ic_addr;
    flush_s = fetch_ic_flush;
    chk("flush", {63'd0, fetch_ic_flush}, {63'd0, (~rst | redirect_valid)});
    if (rst && !redirect_valid && fetch_de_valid && de_fetch_ready) begin
      if (sbq.size() == 0) begin
        chk("de_extra", {34'd0, fetch_de_addr}, 64'hffff_ffff_ffff_ffff);
      end else begin
        e = sbq.pop_front();
        chk("de_entry", {1'b0, fetch_de_error, fetch_de_addr, fetch_de_insn}, {1'b0, e});
        if (e.err) begin
          seen_err = 1'b1;
          sbq.delete();
        end
      end
    end
    if (!rst) begin
      sbq.delete();
      exp_pc = RPC;
    end else if (redirect_valid) begin
      sbq.delete();
      exp_pc = redirect_pc;
    end
    if (acc_s) begin
      chk("ic_addr", {34'd0, addr_s}, {34'd0, exp_pc});
      sbq.push_back('{err: err_en && (exp_pc == err_addr), addr: exp_pc, insn: insn_of(exp_pc)});
      exp_pc = exp_pc + 30'd1;
    end
  endtask

  // Advance the clock and the two-stage icache model.
  task automatic half_b();
    @(posedge clk);
    #1;
    if (flush_s) begin
      s1_v = 1'b0;
      s2_v = 1'b0;
    end else begin
      s2_v = s1_v;
      s2_a = s1_a;
      s1_v = acc_s;
      s1_a = addr_s;
    end
    icache_valid = s2_v;
    icache_data  = s2_v ? insn_of(s2_a) : 32'd0;
    icache_error = s2_v && err_en && (s2_a == err_addr);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      half_a();
      half_b();
    end
  endtask

  task automatic do_redirect(input logic [29:0] npc);
    redirect_pc    = npc;
    redirect_valid = 1'b1;
    half_a();
    chk("rd_flush", {63'd0, fetch_ic_flush}, 64'd1);
    chk("rd_req", {63'd0, fetch_ic_req}, 64'd0);
    half_b();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Backpressure from reset release: 4 requests fill the buffer, then drain in order.
    tab[0]  = '{1'b0, 1'b1, 30'h100, 1'b0, 30'h0};
    tab[1]  = '{1'b0, 1'b1, 30'h101, 1'b0, 30'h0};
    tab[2]  = '{1'b0, 1'b1, 30'h102, 1'b0, 30'h0};
    tab[3]  = '{1'b0, 1'b1, 30'h103, 1'b1, 30'h100};
    tab[4]  = '{1'b0, 1'b0, 30'h0,   1'b1, 30'h100};
    tab[5]  = '{1'b0, 1'b0, 30'h0,   1'b1, 30'h100};
    tab[6]  = '{1'b0, 1'b0, 30'h0,   1'b1, 30'h100};
    tab[7]  = '{1'b0, 1'b0, 30'h0,   1'b1, 30'h100};
    tab[8]  = '{1'b0, 1'b0, 30'h0,   1'b1, 30'h100};
    tab[9]  = '{1'b0, 1'b0, 30'h0,   1'b1, 30'h100};
    tab[10] = '{1'b1, 1'b0, 30'h0,   1'b1, 30'h100};
    tab[11] = '{1'b1, 1'b1, 30'h104, 1'b1, 30'h101};
    tab[12] = '{1'b1, 1'b1, 30'h105, 1'b1, 30'h102};
    tab[13] = '{1'b1, 1'b1, 30'h106, 1'b1, 30'h103};
    tab[14] = '{1'b1, 1'b1, 30'h107, 1'b1, 30'h104};

    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 30'h0;
    icache_ready = 1'b1; icache_valid = 1'b0; icache_error = 1'b0; icache_data = 32'd0;
    de_fetch_ready = 1'b0; err_en = 1'b0; err_addr = 30'h0; seen_err = 1'b0;
    s1_v = 1'b0; s2_v = 1'b0; s1_a = 30'h0; s2_a = 30'h0; exp_pc = RPC;
    acc_s = 1'b0; flush_s = 1'b1; addr_s = 30'h0;

    tick(1);
    for (int i = 0; i < 2; i++) begin
      half_a();
      chk("rst_req", {63'd0, fetch_ic_req}, 64'd0);
      chk("rst_dv", {63'd0, fetch_de_valid}, 64'd0);
      half_b();
    end

    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      de_fetch_ready = tab[i].rdy;
      half_a();
      chk($sformatf("tab%0d_req", i), {63'd0, fetch_ic_req}, {63'd0, tab[i].req});
      if (tab[i].req) chk($sformatf("tab%0d_addr", i), {34'd0, fetch_ic_addr}, {34'd0, tab[i].addr});
      chk($sformatf("tab%0d_dv", i), {63'd0, fetch_de_valid}, {63'd0, tab[i].dv});
      if (tab[i].dv) chk($sformatf("tab%0d_da", i), {34'd0, fetch_de_addr}, {34'd0, tab[i].da});
      half_b();
    end
    tick(8);

    // Redirect with reads both in flight and buffered.
    de_fetch_ready = 1'b0;
    tick(2);
    do_redirect(30'h2000);
    de_fetch_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      half_a();
      if (k == 1) chk("rd_addr", {34'd0, fetch_ic_addr}, 64'h2000);
      chk($sformatf("rd_dv%0d", k), {63'd0, fetch_de_valid}, {63'd0, k == 4});
      if (k == 4) chk("rd_da", {34'd0, fetch_de_addr}, 64'h2000);
      half_b();
    end
    tick(4);

    // Fault on 0x105 halts fetch until the next redirect.
    err_en = 1'b1; err_addr = 30'h105;
    do_redirect(30'h100);
    tick(12);
    for (int k = 0; k < 4; k++) begin
      half_a();
      chk("halt_req", {63'd0, fetch_ic_req}, 64'd0);
      chk("halt_dv", {63'd0, fetch_de_valid}, 64'd0);
      half_b();
    end
    chk("err_seen", {63'd0, seen_err}, 64'd1);
    err_en = 1'b0;
    do_redirect(30'h40);
    half_a();
    chk("resume_req", {63'd0, fetch_ic_req}, 64'd1);
    chk("resume_addr", {34'd0, fetch_ic_addr}, 64'h40);
    half_b();
    tick(6);

    // Address wrap at the top of the word space.
    do_redirect(30'h3fffffff);
    for (int k = 1; k <= 5; k++) begin
      half_a();
      if (k == 1) chk("wrap_ic0", {34'd0, fetch_ic_addr}, 64'h3fffffff);
      if (k == 2) chk("wrap_ic1", {34'd0, fetch_ic_addr}, 64'h0);
      if (k == 4) chk("wrap_de0", {34'd0, fetch_de_addr}, 64'h3fffffff);
      if (k == 5) chk("wrap_de1", {34'd0, fetch_de_addr}, 64'h0);
      half_b();
    end
    tick(4);

    // Reset mid-stream with a partially full buffer.
    de_fetch_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    half_a();
    chk("mrst_req", {63'd0, fetch_ic_req}, 64'd0);
    half_b();
    half_a();
    chk("mrst_dv", {63'd0, fetch_de_valid}, 64'd0);
    half_b();
    rst = 1'b1;
    de_fetch_ready = 1'b1;
    half_a();
    chk("mrst_addr", {34'd0, fetch_ic_addr}, {34'd0, RPC});
    half_b();
    tick(6);

    // Random backpressure on both sides with occasional redirects.
    for (int i = 0; i < 400; i++) begin
      de_fetch_ready = ($urandom_range(0, 2) != 0);
      icache_ready   = ($urandom_range(0, 3) != 0);
      if (i % 97 == 50) do_redirect(30'($urandom()));
      else tick(1);
    end
    de_fetch_ready = 1'b1;
    icache_ready   = 1'b1;
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
